// File: rtl/nvme_perst_pkg.sv
// Shared state encodings and default timing constants for the PERST# sequencer.
package nvme_perst_pkg;

   typedef enum logic [2:0] {
      StAssert = 3'd0,
      StTrain  = 3'd1,
      StUp     = 3'd2,
      StError  = 3'd3
   } perst_state_e;

   localparam int unsigned DefMinAssertCyc    = 25000;     // 100 us at 4 ns
   localparam int unsigned DefTrainTimeoutCyc = 25000000;  // 100 ms at 4 ns
   localparam int unsigned DefCntW            = 16;
   localparam int unsigned MaxRetries         = 3;

endpackage

// File: rtl/nvme_sat_counter.sv
// Saturating event counter; clear takes priority over a same-cycle increment.
module nvme_sat_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/nvme_pcie_perst_seq.sv
// PCIe PERST# sequencer: minimum assert time, link-training timeout, event counters.
// Optional NVME_PERST_SEQ_AUTO_RETRY_EN: up to 3 automatic re-asserts on training timeout.
module nvme_pcie_perst_seq
   import nvme_perst_pkg::*;
#(
   parameter int unsigned MIN_ASSERT_CYC    = DefMinAssertCyc,
   parameter int unsigned TRAIN_TIMEOUT_CYC = DefTrainTimeoutCyc,
   parameter int unsigned CNT_W             = DefCntW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             perst_req,
   input  logic             pcie_xx_link_up,
   input  logic             cnt_clr,
   output logic             pcie_perst_n,
   output logic [2:0]       seq_state,
   output logic             seq_link_up,
   output logic             seq_train_err,
   output logic [CNT_W-1:0] seq_perst_cnt,
   output logic [CNT_W-1:0] seq_linkdown_cnt
);

   localparam logic [31:0] AssertLoad = 32'(MIN_ASSERT_CYC - 1);
   localparam logic [31:0] TrainLoad  = 32'(TRAIN_TIMEOUT_CYC);

   perst_state_e state_q, state_d;
   logic [31:0]  dly_q, dly_d;
   logic         perst_n_q;
   logic         timeout;
   logic         perst_inc;
   logic         linkdown_inc;

   assign timeout = (state_q == StTrain) && !perst_req && !pcie_xx_link_up && (dly_q == 32'd0);

`ifdef NVME_PERST_SEQ_AUTO_RETRY_EN
   logic [1:0] retry_q, retry_d;

   always_comb begin
      retry_d = retry_q;
      if (timeout && (retry_q < 2'(MaxRetries))) begin
         retry_d = retry_q + 2'd1;
      end else if ((state_d == StUp) && (state_q != StUp)) begin
         retry_d = 2'd0;
      end else if (perst_req && (state_d == StAssert) && (state_q != StAssert)) begin
         retry_d = 2'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retry_q <= 2'd0;
      end else begin
         retry_q <= retry_d;
      end
   end
`endif

   // State register; PERST# is registered from the next state so it follows by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StAssert;
         dly_q     <= AssertLoad;
         perst_n_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         dly_q     <= dly_d;
         perst_n_q <= (state_d != StAssert);
      end
   end

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
      case (state_q)
         StAssert: begin
            if (dly_q != 32'd0) begin
               dly_d = dly_q - 32'd1;
            end else if (!perst_req) begin
               state_d = StTrain;
               dly_d   = TrainLoad;
            end
         end
         StTrain: begin
            if (perst_req) begin
               state_d = StAssert;
               dly_d   = AssertLoad;
            end else if (pcie_xx_link_up) begin
               state_d = StUp;
            end else if (timeout) begin
`ifdef NVME_PERST_SEQ_AUTO_RETRY_EN
               if (retry_q < 2'(MaxRetries)) begin
                  state_d = StAssert;
                  dly_d   = AssertLoad;
               end else begin
                  state_d = StError;
               end
`else
               state_d = StError;
`endif
            end else begin
               dly_d = dly_q - 32'd1;
            end
         end
         StUp: begin
            if (perst_req) begin
               state_d = StAssert;
               dly_d   = AssertLoad;
            end else if (!pcie_xx_link_up) begin
               state_d = StTrain;
               dly_d   = TrainLoad;
            end
         end
         StError: begin
            if (perst_req) begin
               state_d = StAssert;
               dly_d   = AssertLoad;
            end
         end
         default: begin
            state_d = StAssert;
            dly_d   = AssertLoad;
         end
      endcase
   end

   always_comb begin
      pcie_perst_n  = perst_n_q;
      seq_state     = state_q;
      seq_link_up   = (state_q == StUp);
      seq_train_err = (state_q == StError);
   end

   // Reset entry never passes through this path, so it is not counted.
   assign perst_inc    = (state_d == StAssert) && (state_q != StAssert);
   assign linkdown_inc = (state_q == StUp) && !perst_req && !pcie_xx_link_up;

   nvme_sat_counter #(
      .CNT_W (CNT_W)
   ) u_perst_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (perst_inc),
      .clr   (cnt_clr),
      .cnt   (seq_perst_cnt)
   );

   nvme_sat_counter #(
      .CNT_W (CNT_W)
   ) u_linkdown_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (linkdown_inc),
      .clr   (cnt_clr),
      .cnt   (seq_linkdown_cnt)
   );

endmodule

// File: tb/tb_nvme_pcie_perst_seq.sv
// Bench for nvme_pcie_perst_seq: vector table, corner sequences, random run vs reference model.
module tb_nvme_pcie_perst_seq;

   localparam int MinCyc = 8;
   localparam int TrnCyc = 32;
   localparam int CntW   = 3;
   localparam int CntMax = (1 << CntW) - 1;

   logic            clk = 1'b0;
   logic            reset;
   logic            perst_req = 1'b0;
   logic            link_up = 1'b0;
   logic            cnt_clr = 1'b0;
   logic            pcie_perst_n;
   logic [2:0]      seq_state;
   logic            seq_link_up;
   logic            seq_train_err;
   logic [CntW-1:0] seq_perst_cnt;
   logic [CntW-1:0] seq_linkdown_cnt;

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   nvme_pcie_perst_seq #(
      .MIN_ASSERT_CYC    (MinCyc),
      .TRAIN_TIMEOUT_CYC (TrnCyc),
      .CNT_W             (CntW)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .perst_req        (perst_req),
      .pcie_xx_link_up  (link_up),
      .cnt_clr          (cnt_clr),
      .pcie_perst_n     (pcie_perst_n),
      .seq_state        (seq_state),
      .seq_link_up      (seq_link_up),
      .seq_train_err    (seq_train_err),
      .seq_perst_cnt    (seq_perst_cnt),
      .seq_linkdown_cnt (seq_linkdown_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: mode (0 assert,1 train,2 up,3 error), cycles spent in current phase.
   int m_mode = 0, m_low = 0, m_wait = 0, m_pc = 0, m_lc = 0, m_retry = 0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_mode <= 0; m_low <= 0; m_wait <= 0; m_pc <= 0; m_lc <= 0; m_retry <= 0;
      end else begin : step
         int nm, nlow, nwait, nrt;
         bit enter_a, drop;
         nm = m_mode; nlow = m_low + 1; nwait = m_wait + 1; nrt = m_retry;
         enter_a = 1'b0; drop = 1'b0;
         case (m_mode)
            0: if (m_low >= MinCyc - 1 && !perst_req) begin nm = 1; nwait = 0; end
            1: begin
               if (perst_req) begin enter_a = 1'b1; nrt = 0; end
               else if (link_up) begin nm = 2; nrt = 0; end
               else if (m_wait >= TrnCyc) begin
`ifdef NVME_PERST_SEQ_AUTO_RETRY_EN
                  if (m_retry < 3) begin enter_a = 1'b1; nrt = m_retry + 1; end
                  else nm = 3;
`else
                  nm = 3;
`endif
               end
            end
            2: begin
               if (perst_req) begin enter_a = 1'b1; nrt = 0; end
               else if (!link_up) begin nm = 1; nwait = 0; drop = 1'b1; end
            end
            default: if (perst_req) begin enter_a = 1'b1; nrt = 0; end
         endcase
         if (enter_a) begin nm = 0; nlow = 0; end
         m_mode  <= nm;
         m_low   <= nlow;
         m_wait  <= nwait;
         m_retry <= nrt;
         m_pc    <= cnt_clr ? 0 : ((enter_a && m_pc < CntMax) ? m_pc + 1 : m_pc);
         m_lc    <= cnt_clr ? 0 : ((drop && m_lc < CntMax) ? m_lc + 1 : m_lc);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model state", int'(seq_state), m_mode);
         check("model perst_n", int'(pcie_perst_n), int'(m_mode != 0));
         check("model link_up", int'(seq_link_up), int'(m_mode == 2));
         check("model train_err", int'(seq_train_err), int'(m_mode == 3));
         check("model perst_cnt", int'(seq_perst_cnt), m_pc);
         check("model linkdown_cnt", int'(seq_linkdown_cnt), m_lc);
      end
   end

   typedef struct {
      logic req;
      logic link;
      logic clr;
      int   cycles;
      int   st;
      int   pn;
      int   pc;
      int   lc;
   } vec_t;

   vec_t vt[13];

   task automatic count_low(output int n);
      n = 0;
      while (pcie_perst_n == 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      int n, exp_n, exp_pc;

      //        req   link  clr  cyc st pn pc lc
      vt[0]  = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0};
      vt[1]  = '{1'b0, 1'b0, 1'b0, 7, 0, 0, 0, 0};
      vt[2]  = '{1'b0, 1'b0, 1'b0, 1, 1, 1, 0, 0};
      vt[3]  = '{1'b0, 1'b0, 1'b0, 11, 1, 1, 0, 0};
      vt[4]  = '{1'b0, 1'b1, 1'b0, 1, 2, 1, 0, 0};
      vt[5]  = '{1'b1, 1'b1, 1'b0, 1, 0, 0, 1, 0};
      vt[6]  = '{1'b0, 1'b1, 1'b0, 7, 0, 0, 1, 0};
      vt[7]  = '{1'b0, 1'b1, 1'b0, 1, 1, 1, 1, 0};
      vt[8]  = '{1'b0, 1'b1, 1'b0, 1, 2, 1, 1, 0};
      vt[9]  = '{1'b0, 1'b0, 1'b0, 1, 1, 1, 1, 1};
      vt[10] = '{1'b0, 1'b0, 1'b0, 4, 1, 1, 1, 1};
      vt[11] = '{1'b0, 1'b1, 1'b0, 1, 2, 1, 1, 1};
      vt[12] = '{1'b0, 1'b1, 1'b1, 1, 2, 1, 0, 0};

      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      chk_en = 1'b1;

      foreach (vt[i]) begin
         perst_req = vt[i].req;
         link_up   = vt[i].link;
         cnt_clr   = vt[i].clr;
         repeat (vt[i].cycles) @(negedge clk);
         check($sformatf("vec%0d state", i), int'(seq_state), vt[i].st);
         check($sformatf("vec%0d perst_n", i), int'(pcie_perst_n), vt[i].pn);
         check($sformatf("vec%0d perst_cnt", i), int'(seq_perst_cnt), vt[i].pc);
         check($sformatf("vec%0d linkdown_cnt", i), int'(seq_linkdown_cnt), vt[i].lc);
      end
      perst_req = 1'b0;
      cnt_clr   = 1'b0;

      // Training timeout from UP: one edge into TRAIN, 33 TRAIN cycles, then ERROR.
`ifdef NVME_PERST_SEQ_AUTO_RETRY_EN
      exp_n  = 34 + 3 * (MinCyc + TrnCyc + 1);
      exp_pc = 3;
`else
      exp_n  = 34;
      exp_pc = 0;
`endif
      link_up = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!seq_train_err && n < 300);
      check("timeout cycles", n, exp_n);
      check("timeout perst_cnt", int'(seq_perst_cnt), exp_pc);

      // One-cycle request pulse still yields the full minimum assert time.
      perst_req = 1'b1;
      @(negedge clk);
      perst_req = 1'b0;
      count_low(n);
      check("pulse low cycles", n, MinCyc);

      // Saturation, then clear beating a same-cycle increment.
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      for (int k = 0; k < CntMax + 2; k++) begin
         perst_req = 1'b1;
         @(negedge clk);
         perst_req = 1'b0;
         repeat (10) @(negedge clk);
      end
      check("saturated perst_cnt", int'(seq_perst_cnt), CntMax);
      perst_req = 1'b1;
      cnt_clr   = 1'b1;
      @(negedge clk);
      perst_req = 1'b0;
      cnt_clr   = 1'b0;
      check("clr wins perst_cnt", int'(seq_perst_cnt), 0);
      check("clr wins perst_n", int'(pcie_perst_n), 0);

      // Asynchronous reset during TRAIN.
      n = 0;
      while (seq_state != 3'd1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      check("reached train", int'(seq_state), 1);
      repeat (9) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async reset perst_n", int'(pcie_perst_n), 0);
      check("async reset state", int'(seq_state), 0);
      @(negedge clk);
      reset = 1'b0;
      count_low(n);
      check("post-reset low cycles", n, MinCyc);
      check("post-reset perst_cnt", int'(seq_perst_cnt), 0);

      // Random traffic against the model.
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(7) == 0) link_up = ~link_up;
         perst_req = ($urandom_range(39) == 0);
         cnt_clr   = ($urandom_range(63) == 0);
         @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/nvme_pcie_perst_seq.md
NVME_PCIE_PERST_SEQ -- requirements
Module: nvme_pcie_perst_seq

Interface
REQ-001 SHALL have parameter MIN_ASSERT_CYC, default 25000, minimum PERST# low time in clk cycles (100 us at 4 ns).
REQ-002 SHALL have parameter TRAIN_TIMEOUT_CYC, default 25000000, maximum wait for link up after PERST# release (100 ms).
REQ-003 SHALL have parameter CNT_W, default 16, width of the event counters.
REQ-004 SHALL have port clk, input, 1, the only clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-006 SHALL have port perst_req, input, 1, PERST request from the perst mux stage (1 = assert).
REQ-007 SHALL have port pcie_xx_link_up, input, 1, PCIe core link-up, synchronous to clk.
REQ-008 SHALL have port cnt_clr, input, 1, single-cycle clear of both counters.
REQ-009 SHALL have port pcie_perst_n, output, 1, registered PERST# to the PCIe core/slot (0 = asserted).
REQ-010 SHALL have port seq_state, output, 3, current state encoding.
REQ-011 SHALL have port seq_link_up, output, 1, high only in state UP.
REQ-012 SHALL have port seq_train_err, output, 1, high only in state ERROR.
REQ-013 SHALL have port seq_perst_cnt, output, CNT_W, number of PERST assertions.
REQ-014 SHALL have port seq_linkdown_cnt, output, CNT_W, number of unrequested link drops.

Function
REQ-015 SHALL implement states ASSERT=0, TRAIN=1, UP=2, ERROR=3; encodings 4-7 SHALL return to ASSERT next cycle.
REQ-016 ASSERT: pcie_perst_n=0; dly counter decrements to 0; at 0 with perst_req=0 -> TRAIN and load TRAIN_TIMEOUT_CYC; at 0 with perst_req=1 -> remain.
REQ-017 TRAIN: pcie_perst_n=1; priority perst_req=1 -> ASSERT, else link_up=1 -> UP, else dly==0 -> ERROR, else decrement.
REQ-018 UP: perst_req=1 -> ASSERT; else link_up=0 -> TRAIN, reload TRAIN_TIMEOUT_CYC, seq_linkdown_cnt++.
REQ-019 ERROR: pcie_perst_n=1; perst_req=1 -> ASSERT; otherwise hold.
REQ-020 Every entry to ASSERT from a non-ASSERT state SHALL load MIN_ASSERT_CYC-1 and increment seq_perst_cnt.
REQ-021 pcie_perst_n SHALL be registered from the next state: perst_req sampled high at edge N drives pcie_perst_n low after edge N (1-cycle latency).
REQ-022 PERST# low time SHALL be at least MIN_ASSERT_CYC cycles even if perst_req is a 1-cycle pulse.
REQ-023 Counters SHALL saturate at all-ones; cnt_clr SHALL win over a same-cycle increment.
REQ-024 Down-counter SHALL be 32 bits; parameters SHALL be truncated to [31:0].

Reset
REQ-025 On reset: state=ASSERT, dly=MIN_ASSERT_CYC-1, pcie_perst_n=0, seq_link_up=0, seq_train_err=0, both counters=0.
REQ-026 Reset mid-operation SHALL re-assert PERST# immediately (asynchronously) and restart a full ASSERT period; the reset entry SHALL NOT count in seq_perst_cnt.

Configuration
REQ-027 With NVME_PERST_SEQ_AUTO_RETRY_EN defined, a TRAIN timeout SHALL go to ASSERT (counted) up to 3 times per request; the 4th timeout -> ERROR; the retry count clears on entry to UP or on a perst_req-initiated ASSERT.
REQ-028 Without NVME_PERST_SEQ_AUTO_RETRY_EN, a TRAIN timeout SHALL go straight to ERROR; no retry logic synthesised.

Structure
REQ-029 State encodings and default timing constants SHALL live in the shared package nvme_perst_pkg.
REQ-030 One sub-module nvme_sat_counter (CNT_W, inc, clr, saturate) SHALL be instantiated twice; no other hierarchy.

Verification (MIN_ASSERT_CYC=8, TRAIN_TIMEOUT_CYC=32)
REQ-031 Release reset, perst_req=0, link_up high at cycle 20 -> pcie_perst_n low 8 cycles, then high; UP; seq_perst_cnt=0.
REQ-032 In UP, 1-cycle perst_req pulse -> pcie_perst_n low next cycle for exactly 8 cycles; seq_perst_cnt=1.
REQ-033 In UP, drop link_up for 5 cycles -> TRAIN then UP; seq_linkdown_cnt=1; pcie_perst_n stays high.
REQ-034 link_up never rises -> seq_train_err=1 after 32 TRAIN cycles (no macro); with macro, 3 extra ASSERT periods, seq_perst_cnt=3, then ERROR.
REQ-035 Force seq_perst_cnt to 0xFFFF, pulse perst_req -> stays 0xFFFF; cnt_clr and perst_req same cycle -> 0.
REQ-036 Assert reset in TRAIN cycle 10 -> pcie_perst_n=0 within the reset cycle; full 8-cycle ASSERT after release.
